// File: rtl/alu_issue.sv
// alu_issue: decodes OP/OP-IMM/LUI/AUIPC into ALU controls and operands,
// issued through a registered two-entry elastic buffer.
module alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] operand_1,
  output logic [XLEN-1:0] operand_2,
  output logic [4:0]      rd,
  output logic            illegal
);

  typedef struct packed {
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [4:0]      rd;
    logic            ill;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  state_t          state;
  state_t          state_n;
  entry_t          dec;
  entry_t          out_q;
  entry_t          skid_q;
  logic            accept;
  logic            drain;
  logic            legal;
  logic [6:0]      opcode;
  logic [6:0]      f7_raw;
  logic [2:0]      f3_raw;
  logic [6:0]      sh_hi;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;
  logic            unused_rs1_field;

  assign opcode = instr[6:0];
  assign f3_raw = instr[14:12];
  assign f7_raw = instr[31:25];
  assign imm_i  = XLEN'($signed(instr[31:20]));
  assign imm_u  = XLEN'($signed({instr[31:12], 12'b0}));
  assign unused_rs1_field = ^instr[19:15];

  // sh_hi holds the bits above shamt, aligned so bit 5 is instr[30]
  if (XLEN == 64) begin : g_sh64
    assign shamt = XLEN'(instr[25:20]);
    assign sh_hi = {instr[31:26], 1'b0};
  end else begin : g_sh32
    assign shamt = XLEN'(instr[24:20]);
    assign sh_hi = instr[31:25];
  end

  always_comb begin
    dec   = '0;
    legal = 1'b0;
    unique case (1'b1)
      opcode == OPC_OP: begin
        dec.op1 = rs1_data;
        dec.op2 = rs2_data;
        dec.f3  = f3_raw;
        dec.f7  = f7_raw;
        legal   = (f7_raw == 7'b0) ||
                  (f7_raw == F7_ALT &&
                   (f3_raw == 3'b000 || f3_raw == 3'b101));
      end
      opcode == OPC_IMM: begin
        dec.op1 = rs1_data;
        dec.f3  = f3_raw;
        unique case (f3_raw)
          3'b001: begin
            dec.op2 = shamt;
            legal   = sh_hi == 7'b0;
          end
          3'b101: begin
            dec.op2 = shamt;
            dec.f7  = instr[30] ? F7_ALT : 7'b0;
            legal   = (sh_hi & ~F7_ALT) == 7'b0;
          end
          default: begin
            dec.op2 = imm_i;
            legal   = 1'b1;
          end
        endcase
      end
      opcode == OPC_LUI: begin
        dec.op2 = imm_u;
        legal   = 1'b1;
      end
      opcode == OPC_AUIPC: begin
        dec.op1 = pc;
        dec.op2 = imm_u;
        legal   = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (legal) begin
      dec.rd = instr[11:7];
    end else begin
      dec     = '0;
      dec.ill = 1'b1;
    end
  end

  assign out_valid = state != EMPTY;
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_comb begin
    state_n = state;
    unique case (state)
      EMPTY: if (accept) state_n = ONE;
      ONE: begin
        if (accept && !drain) state_n = TWO;
        else if (drain && !accept) state_n = EMPTY;
      end
      TWO: if (drain) state_n = ONE;
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_n;
      in_ready <= state_n != TWO;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      skid_q <= '0;
    end else if (state == TWO) begin
      if (drain) out_q <= skid_q;
    end else if (accept) begin
      if (state == EMPTY || drain) out_q <= dec;
      else skid_q <= dec;
    end
  end

  assign funct3    = out_q.f3;
  assign funct7    = out_q.f7;
  assign operand_1 = out_q.op1;
  assign operand_2 = out_q.op2;
  assign rd        = out_q.rd;
  assign illegal   = out_q.ill;

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
Issue stage that sits directly upstream of the integer ALU in the IEU. It accepts a raw RV32I/RV64I instruction with its PC and register-file read data, and decodes OP, OP-IMM, LUI and AUIPC. It drives the ALU control pair (funct3/funct7) and the two operands through a registered, valid/ready, 2-entry elastic buffer. Unsupported encodings pass through flagged illegal so that a later stage raises the exception.

Parameters:
XLEN, 32, datapath width; 32 or 64 only. It sets operand widths and the shamt field width: 5 bits at XLEN=32, 6 bits at XLEN=64.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream presents an instruction
in_ready  output  1  stage can accept; registered
instr  input  32  raw instruction word
pc  input  XLEN  instruction address
rs1_data  input  XLEN  register rs1 value
rs2_data  input  XLEN  register rs2 value
out_valid  output  1  decoded entry available to ALU
out_ready  input  1  ALU/writeback consumes entry
funct3  output  3  ALU op select
funct7  output  7  ALU op modifier; only 0000000 or 0100000 ever driven
operand_1  output  XLEN  ALU operand 1
operand_2  output  XLEN  ALU operand 2
rd  output  5  destination register
illegal  output  1  entry is not a legal ALU-class instruction

Behaviour:
- Reset (synchronous, active-high), taking effect on the next clk edge, including mid-transfer:
  - out_valid=0, in_ready=1.
  - funct3, funct7, operand_1, operand_2, rd and illegal all 0.
  - Both buffer slots empty; any in-flight entry is dropped.
- Handshakes:
  - Input transfer occurs on in_valid && in_ready.
  - Output transfer occurs on out_valid && out_ready.
  - Outputs hold stable while out_valid && !out_ready.
  - in_valid is ignored when in_ready=0.
- Latency: an accepted instruction appears on the outputs the next cycle if the output slot is empty or draining that cycle.
- Buffer: an output register plus one skid register; order is strictly preserved.
  - Slot states: EMPTY, ONE (output valid), TWO (output + skid valid).
  - EMPTY -> ONE on accept.
  - ONE -> TWO on accept without drain.
  - ONE -> EMPTY on drain without accept.
  - ONE -> ONE on accept and drain together.
  - TWO -> ONE on drain: the skid entry moves into the output register. There is no accept in TWO because in_ready=0.
  - in_ready = (state != TWO), registered.
  - Full throughput (1 per cycle) is sustained when out_ready=1 continuously.
- Decode, with opcode = instr[6:0]. immI = sext(instr[31:20]); immU = sext({instr[31:12], 12'b0}) to XLEN.
  - OP (0110011):
    - op1 = rs1, op2 = rs2, funct3 = instr[14:12], funct7 = instr[31:25].
    - Legal if funct7 = 0000000, or if funct7 = 0100000 with funct3 ∈ {000, 101}.
    - Otherwise illegal.
  - OP-IMM (0010011), op1 = rs1, funct3 = instr[14:12]:
    - funct3 ∉ {001, 101}: op2 = immI, funct7 = 0000000.
    - funct3 = 001 (SLLI): op2 = zero-extended shamt, which is instr[24:20] at XLEN=32 or instr[25:20] at XLEN=64. funct7 = 0000000. Illegal unless the bits above shamt in instr[31:25/26] are all 0.
    - funct3 = 101: same op2 as SLLI. funct7 = 0100000 if instr[30]=1 (SRAI), else 0000000 (SRLI). Illegal unless the remaining upper bits (excluding bit 30) are 0.
  - LUI (0110111): op1 = 0, op2 = immU, funct3 = 000, funct7 = 0000000.
  - AUIPC (0010111): op1 = pc, op2 = immU, funct3 = 000, funct7 = 0000000.
  - Any other opcode: illegal.
- Illegal entries: illegal=1, funct3/funct7/operands/rd all 0. They are still transferred and still occupy a slot.
- Legal entries: rd = instr[11:7], illegal=0. rd=0 is passed unchanged; discarding writes to x0 is the writeback's job.
- Decode is combinational on the input side and captured into whichever slot is written. The skid slot holds fully decoded values.

Test Plan:
- ADD/SUB: instr=0x002081B3 (add x3,x1,x2), rs1=5, rs2=7, out_ready=1 → next cycle out_valid=1, funct3=000, funct7=0000000, op1=5, op2=7, rd=3. Then 0x402081B3 → funct7=0100000.
- Immediates: addi x1,x0,-1 (0xFFF00093) → op2=0xFFFFFFFF, funct7=0. srai x1,x1,3 (0x4030D093) → op2=3, funct7=0100000, funct3=101. slli with instr[25]=1 at XLEN=32 → illegal=1.
- U-type: lui x5,0x12345 (0x123452B7) → op1=0, op2=0x12345000. auipc with pc=0x100 (0x00001297) → op1=0x100, op2=0x1000, funct3=000.
- Backpressure: stream 3 instrs with out_ready=0.
  - First 2 accepted; in_ready falls after the second.
  - Raise out_ready → outputs emerge in order, 1 per cycle.
  - in_ready reasserts the cycle after the first drain; the third instruction is accepted with no loss or duplication.
- Illegal: opcode 0000011 (load) → illegal=1, rd=0, operands 0, transferred once. OP with funct7=0000001 → illegal=1.
- Reset mid-stream: assert reset with the buffer in TWO → next cycle out_valid=0, in_ready=1, all outputs 0. A later accept behaves as from EMPTY.
